// File: rtl/led_pattern_seq_pkg.sv
// Shared encodings for the LED pattern sequencer: display modes, bounce
// direction and the pattern each mode starts from.
package led_pattern_seq_pkg;

  typedef enum logic [1:0] {
    MODE_LEFT   = 2'd0,
    MODE_RIGHT  = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_BOUNCE = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  localparam logic [3:0] INIT_LEFT   = 4'b0001;
  localparam logic [3:0] INIT_RIGHT  = 4'b1000;
  localparam logic [3:0] INIT_BLINK  = 4'b0000;
  localparam logic [3:0] INIT_BOUNCE = 4'b0001;

  // Mode sequence on each accepted press: LEFT -> RIGHT -> BLINK -> BOUNCE -> LEFT.
  function automatic mode_t next_mode(input mode_t m);
    case (m)
      MODE_LEFT:   return MODE_RIGHT;
      MODE_RIGHT:  return MODE_BLINK;
      MODE_BLINK:  return MODE_BOUNCE;
      default:     return MODE_LEFT;
    endcase
  endfunction

  // Pattern loaded into the LED register when a mode is entered.
  function automatic logic [3:0] init_pattern(input mode_t m);
    case (m)
      MODE_LEFT:   return INIT_LEFT;
      MODE_RIGHT:  return INIT_RIGHT;
      MODE_BLINK:  return INIT_BLINK;
      default:     return INIT_BOUNCE;
    endcase
  endfunction

endpackage

// File: rtl/led_pattern_seq_key_filter.sv
// Push-button filter: synchronises the raw active-low key, requires it to be
// stable low for DEBOUNCE_MAX cycles and emits one pulse per held press.
module key_filter #(
  parameter int unsigned DEBOUNCE_MAX = 20'd999_999,
  parameter int unsigned DB_W         = 20
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_in,
  output logic key_press
);

  localparam logic [DB_W-1:0] CNT_MAX = DB_W'(DEBOUNCE_MAX);
  localparam logic [DB_W-1:0] CNT_ARM = DB_W'(DEBOUNCE_MAX - 1);

  logic            key_s1;
  logic            key_s2;
  logic [DB_W-1:0] cnt;

  // Two-flop synchroniser; resets to the released (high) level.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_s1 <= 1'b1;
      key_s2 <= 1'b1;
    end else begin
      key_s1 <= key_in;
      key_s2 <= key_s1;
    end
  end

  // Stable-low counter: clears on release, saturates while held.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt <= '0;
    end else if (key_s2) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  // The counter passes through DEBOUNCE_MAX-1 exactly once per held press,
  // because saturation stops it there on the following cycle.
  assign key_press = (cnt == CNT_ARM);

endmodule

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: four display modes stepped by a debounced button,
// pattern advanced once per period-counter tick.
module led_pattern_seq
  import led_pattern_seq_pkg::*;
#(
  parameter int unsigned LED_W        = 4,
  parameter int unsigned DEBOUNCE_MAX = 20'd999_999,
  parameter int unsigned DB_W         = 20
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             tick_in,
  input  logic             key_in,
  output logic [LED_W-1:0] led_out,
  output logic [1:0]       mode_out
);

  logic             key_press;
  mode_t            mode_q;
  mode_t            mode_nxt;
  dir_t             dir_q;
  logic [LED_W-1:0] led_q;

  key_filter #(
    .DEBOUNCE_MAX (DEBOUNCE_MAX),
    .DB_W         (DB_W)
  ) u_key_filter (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key_in    (key_in),
    .key_press (key_press)
  );

  // Mode that the next accepted press selects.
  always_comb begin
    mode_nxt = next_mode(mode_q);
  end

  // Mode FSM and pattern register; a press takes priority over a same-cycle tick.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mode_q <= MODE_LEFT;
      dir_q  <= DIR_LEFT;
      led_q  <= LED_W'(INIT_LEFT);
    end else if (key_press) begin
      mode_q <= mode_nxt;
      led_q  <= LED_W'(init_pattern(mode_nxt));
      if (mode_nxt == MODE_BOUNCE) begin
        dir_q <= DIR_LEFT;
      end
    end else if (tick_in) begin
      case (mode_q)
        MODE_LEFT:  led_q <= {led_q[LED_W-2:0], led_q[LED_W-1]};
        MODE_RIGHT: led_q <= {led_q[0], led_q[LED_W-1:1]};
        MODE_BLINK: led_q <= ~led_q;
        default: begin
          // Direction flips at either end before the shift is applied.
          if (dir_q == DIR_LEFT) begin
            if (led_q[LED_W-1]) begin
              dir_q <= DIR_RIGHT;
              led_q <= led_q >> 1;
            end else begin
              led_q <= led_q << 1;
            end
          end else begin
            if (led_q[0]) begin
              dir_q <= DIR_LEFT;
              led_q <= led_q << 1;
            end else begin
              led_q <= led_q >> 1;
            end
          end
        end
      endcase
    end
  end

  assign led_out  = led_q;
  assign mode_out = mode_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Self-checking bench for led_pattern_seq with a short debounce period.
module tb_led_pattern_seq;

  localparam int unsigned DB_MAX = 20;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       tick_in   = 1'b0;
  logic       key_in    = 1'b1;
  logic [3:0] led_out;
  logic [1:0] mode_out;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned edge_cnt = 0;

  always #5 sys_clk = ~sys_clk;

  led_pattern_seq #(
    .LED_W        (4),
    .DEBOUNCE_MAX (DB_MAX),
    .DB_W         (5)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .tick_in   (tick_in),
    .key_in    (key_in),
    .led_out   (led_out),
    .mode_out  (mode_out)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Mode as 0..3; position as a bit index (LEFT/RIGHT), a lit flag (BLINK)
  // or a phase in the 6-step bounce cycle (BOUNCE).
  int m_mode = 0;
  int m_pos  = 0;
  int raw_run = 0;           // consecutive low samples of the raw key
  bit dl [3] = '{0, 0, 0};   // press decisions waiting out the synchroniser latency
  int bounce_bit [6] = '{0, 1, 2, 3, 2, 1};

  function automatic int model_led();
    logic [3:0] v;
    v = 4'b0001;
    case (m_mode)
      0, 1:    v = v << m_pos;
      2:       v = (m_pos != 0) ? 4'b1111 : 4'b0000;
      default: v = v << bounce_bit[m_pos];
    endcase
    return int'(v);
  endfunction

  task automatic model_enter(input int mode);
    m_mode = mode;
    case (mode)
      1:       m_pos = 3;
      default: m_pos = 0;
    endcase
  endtask

  task automatic model_reset();
    model_enter(0);
    raw_run = 0;
    dl = '{0, 0, 0};
  endtask

  always @(negedge sys_rst_n) model_reset();

  always @(posedge sys_clk) begin
    bit act;
    edge_cnt++;
    if (sys_rst_n) begin
      act   = dl[2];
      dl[2] = dl[1];
      dl[1] = dl[0];
      raw_run = key_in ? 0 : ((raw_run < 1000) ? raw_run + 1 : raw_run);
      // A press is accepted once the key has been low DB_MAX samples; the
      // decision made on the (DB_MAX-1)th sample lands three edges later.
      dl[0] = (raw_run == int'(DB_MAX) - 1);
      if (act) begin
        model_enter((m_mode + 1) % 4);
      end else if (tick_in) begin
        case (m_mode)
          0:       m_pos = (m_pos + 1) % 4;
          1:       m_pos = (m_pos + 3) % 4;
          2:       m_pos = 1 - m_pos;
          default: m_pos = (m_pos + 1) % 6;
        endcase
      end
    end
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge sys_clk) begin
    check_eq("led", int'(led_out), model_led());
    check_eq("mode", int'(mode_out), m_mode);
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(negedge sys_clk);
    #1;
  endtask

  task automatic press(input int hold);
    key_in = 1'b0;
    repeat (hold) cyc();
    key_in = 1'b1;
    repeat (5) cyc();
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      tick_in = 1'b1;
      cyc();
      tick_in = 1'b0;
      cyc();
    end
  endtask

  initial begin
    int unsigned f;
    int lat;
    bit seen;
    int key_left;

    model_reset();
    repeat (3) cyc();
    check_eq("reset_led", int'(led_out), 1);
    check_eq("reset_mode", int'(mode_out), 0);
    sys_rst_n = 1'b1;
    cyc();

    // Free-running rotate-left.
    tick_n(5);
    check_eq("left5_led", int'(led_out), 4'b0010);

    // Glitches shorter than the debounce period, then one long hold.
    repeat (3) begin
      key_in = 1'b0;
      repeat (10) cyc();
      key_in = 1'b1;
      repeat (10) cyc();
    end
    check_eq("glitch_mode", int'(mode_out), 0);
    key_in = 1'b0;
    f = edge_cnt;
    seen = 0;
    lat = -1;
    repeat (40) begin
      cyc();
      if (!seen && mode_out != 2'd0) begin
        seen = 1;
        lat = int'(edge_cnt - f);
      end
    end
    key_in = 1'b1;
    repeat (5) cyc();
    check_eq("press_latency", lat, 22);
    check_eq("right_init", int'(led_out), 4'b1000);
    tick_n(1);
    check_eq("right_step", int'(led_out), 4'b0100);

    // Two more presses into BOUNCE, then walk the bounce sequence.
    press(30);
    press(30);
    check_eq("bounce_mode", int'(mode_out), 3);
    check_eq("bounce_init", int'(led_out), 4'b0001);
    tick_n(7);
    check_eq("bounce7", int'(led_out), 4'b0010);

    // Wrap through LEFT and RIGHT to BLINK, toggle, then wrap again.
    press(25);
    press(25);
    press(25);
    check_eq("blink_init", int'(led_out), 4'b0000);
    tick_n(3);
    check_eq("blink3", int'(led_out), 4'b1111);
    press(25);
    press(25);
    check_eq("wrap_mode", int'(mode_out), 0);
    check_eq("wrap_led", int'(led_out), 4'b0001);

    // Tick aligned with the press edge in LEFT at 0100: the tick is dropped.
    tick_n(2);
    check_eq("pre_align", int'(led_out), 4'b0100);
    key_in = 1'b0;
    repeat (30) begin
      tick_in = dl[2];
      cyc();
      if (tick_in) begin
        check_eq("align_mode", int'(mode_out), 1);
        check_eq("align_led", int'(led_out), 4'b1000);
      end
      tick_in = 1'b0;
    end
    key_in = 1'b1;
    repeat (5) cyc();

    // Reset mid-hold: counter reaches 15, then a fresh full hold is needed.
    key_in = 1'b0;
    repeat (17) cyc();
    sys_rst_n = 1'b0;
    cyc();
    check_eq("midrst_led", int'(led_out), 1);
    check_eq("midrst_mode", int'(mode_out), 0);
    cyc();
    sys_rst_n = 1'b1;
    repeat (20) cyc();
    check_eq("midrst_nopress", int'(mode_out), 0);
    repeat (20) cyc();
    check_eq("midrst_press", int'(mode_out), 1);
    key_in = 1'b1;
    repeat (5) cyc();

    // Random key activity and ticks, sometimes forced onto the press edge.
    key_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (key_left == 0) begin
        key_in   = ~key_in;
        key_left = key_in ? int'($urandom_range(1, 30)) : int'($urandom_range(1, 45));
      end
      key_left--;
      tick_in = ($urandom_range(0, 2) == 0) || (($urandom_range(0, 1) == 1) && dl[2]);
      cyc();
    end
    tick_in = 1'b0;
    key_in  = 1'b1;
    repeat (5) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_pattern_seq.md
Name: led_pattern_seq

Overview:
- Downstream consumer of the period counter's one-cycle tick.
- Drives a 4-LED bank through one of four display modes, advancing the pattern once per tick.
- Mode is selected by a raw push-button, debounced in-block; each press steps to the next mode.
- Sits between the 1 s period counter and the board LED pins.

Parameters:
- LED_W, 4, number of LEDs. Fixed at 4 for this revision.
- DEBOUNCE_MAX, 20'd999_999, stable-low cycles needed to accept a press (20 ms at 50 MHz).
- DB_W, 20, width of the debounce counter. Must hold DEBOUNCE_MAX.

Ports:
- sys_clk  input  1  system clock, 50 MHz.
- sys_rst_n  input  1  asynchronous, active-low reset.
- tick_in  input  1  single-cycle advance pulse from the period counter, synchronous to sys_clk.
- key_in  input  1  raw button, active-low, asynchronous, bouncy.
- led_out  output  4  LED drive, active-high, registered.
- mode_out  output  2  current mode, registered: 0 LEFT, 1 RIGHT, 2 BLINK, 3 BOUNCE.

Behaviour:
- Reset (asynchronous, on sys_rst_n low):
  - mode_out = 0 (LEFT), led_out = 4'b0001, bounce direction = left.
  - Debounce counter = 0; synchroniser flops = 1 (released).
- Key filter:
  - key_in passes through a 2-flop synchroniser.
  - Counter clears while the synchronised key is high.
  - While it is low, the counter increments and saturates at DEBOUNCE_MAX.
  - key_press is a one-cycle pulse asserted when the counter == DEBOUNCE_MAX-1.
  - Result: exactly one pulse per held press. A glitch shorter than DEBOUNCE_MAX cycles produces no pulse.
  - A hold of any length produces a single pulse; the key must be released and pressed again for another.
- Mode FSM:
  - States LEFT → RIGHT → BLINK → BOUNCE → LEFT, advancing on key_press. mode_out updates the cycle after the pulse.
  - On a mode change, led_out loads the new mode's initial pattern in the same cycle as mode_out updates:
    - LEFT 0001, RIGHT 1000, BLINK 0000, BOUNCE 0001.
    - BOUNCE also sets direction = left.
- Pattern update: tick_in high at cycle N, with no key_press at N, gives a new led_out at N+1.
  - LEFT: rotate left, wrapping 1000 → 0001.
  - RIGHT: rotate right, wrapping 0001 → 1000.
  - BLINK: led_out = ~led_out, so 0000 ↔ 1111.
  - BOUNCE: shift one position in the current direction.
    - At 1000 the direction flips to right before shifting, giving 0100.
    - At 0001 the direction flips to left, giving 0010.
    - Full sequence: 0001,0010,0100,1000,0100,0010,0001,0010,…
- Simultaneous key_press and tick_in: the mode change wins, the init pattern is loaded, and the tick is dropped.
- No tick: led_out holds indefinitely.
- Reset mid-press: the debounce counter clears. A press still held after reset release needs the full DEBOUNCE_MAX stable-low period again.
- All state lives in flops on sys_clk with asynchronous reset; there are no combinational outputs.

Decomposition:
- Shared package:
  - mode encodings MODE_LEFT/RIGHT/BLINK/BOUNCE (2-bit);
  - per-mode init patterns;
  - DIR_LEFT/DIR_RIGHT.
- One sub-module, key_filter:
  - parameters DEBOUNCE_MAX, DB_W;
  - ports sys_clk, sys_rst_n, key_in, key_press.
- Mode FSM and pattern register remain in led_pattern_seq.

Test Plan (sim with DEBOUNCE_MAX=20):
- Reset then 5 ticks, no key → led_out 0001 → 0010, 0100, 1000, 0001, 0010; mode_out stays 0.
- key_in low with 10-cycle glitches, then held low for 40 cycles → exactly one key_press, 22 cycles after the final falling edge. mode_out=1, led_out=1000; next tick gives 0100.
- Two more clean presses, then ticks → mode_out=3, led_out=0001. Ticks produce 0010, 0100, 1000, 0100, 0010, 0001, 0010.
- From mode 1, press → mode 2, led_out=0000; ticks toggle 1111, 0000, 1111. A fourth press wraps to mode 0 with led_out=0001.
- tick_in and key_press aligned on the same cycle (mode 0, led 0100) → next cycle mode_out=1, led_out=1000, no rotation applied.
- Assert sys_rst_n low mid-hold at debounce count 15 → outputs return to 0001/0; after release with the key still low, a pulse arrives only after a fresh 20-cycle hold.
